dma_mem_to_dev: RTL

Memory-to-device DMA engine, the transmit counterpart of the existing device-to-memory DMA. The CPU issues a command with a base address and word count. The block steals the data bus with the BR/BG handshake and reads memory one 64-bit line (4 words) at a time. It streams each line word by word to an external device, tagging each word with its offset, and pulses an interrupt when the transfer completes. It sits beside the existing DMA on the shared d_address/d_readM/d_data bus.

---
 rtl/dma_mem_to_dev_if.sv | 30 +++
 rtl/dma_mem_to_dev.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dma_mem_to_dev_if.sv
// Purpose : CPU command and device stream signals of the memory-to-device DMA.
// Latency : n/a (signal bundle only).
// Backpressure: dev_ready from the device stalls the stream; dev_data/dev_offset hold while stalled.
//
// Ports (via modports):
//   master - DMA engine view: takes cmd/cmd_addr/cmd_len/dev_ready, drives busy/interrupt/dev_*.
//   slave  - CPU/device view: drives cmd/cmd_addr/cmd_len/dev_ready, observes busy/interrupt/dev_*.
interface dma_mem_to_dev_if #(
   parameter int WORD_SIZE = 16
) ();
   logic                 cmd;
   logic [WORD_SIZE-1:0] cmd_addr;
   logic [WORD_SIZE-1:0] cmd_len;
   logic                 busy;
   logic                 interrupt;
   logic [WORD_SIZE-1:0] dev_data;
   logic [1:0]           dev_offset;
   logic                 dev_valid;
   logic                 dev_ready;

   modport master (
      input  cmd, cmd_addr, cmd_len, dev_ready,
      output busy, interrupt, dev_data, dev_offset, dev_valid
   );

   modport slave (
      output cmd, cmd_addr, cmd_len, dev_ready,
      input  busy, interrupt, dev_data, dev_offset, dev_valid
   );
endinterface

// File: rtl/dma_mem_to_dev.sv
// Purpose : memory-to-device DMA; steals the bus per 4-word line and streams words to a device.
// Latency : per line 1 REQ + MEM_LATENCY READ + 1 cycle per word (grant and ready immediate).
// Backpressure: dev_ready low holds the current word; BG loss during READ re-requests the same line.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   ctl (master)        - cmd/cmd_addr/cmd_len in, busy/interrupt out, dev_data/dev_offset/dev_valid out, dev_ready in
//   BR / BG             - bus request out / bus grant in
//   d_readM, d_address  - memory read strobe and line address, high-Z while the bus is not owned
//   d_data              - memory read line, word k at d_data[16k+15:16k]
//
// Build option: define DMA_BURST_HOLD_EN to keep BR asserted for the whole transfer and go
// straight from STREAM to READ while the grant is still held.
module dma_mem_to_dev #(
   parameter int WORD_SIZE   = 16,
   parameter int FETCH_SIZE  = 64,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   dma_mem_to_dev_if.master      ctl,
   output logic                  BR,
   input  logic                  BG,
   output wire                   d_readM,
   output wire [WORD_SIZE-1:0]   d_address,
   input  logic [FETCH_SIZE-1:0] d_data
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_READ,
      S_STREAM,
      S_DONE
   } state_t;

   state_t                state;
   logic [WORD_SIZE-1:0]  addr;
   logic [WORD_SIZE-1:0]  rem;
   logic [FETCH_SIZE-1:0] line;
   logic [CNT_W-1:0]      lat_cnt;
   logic                  own;

   function automatic logic [WORD_SIZE-1:0] word_of(input logic [FETCH_SIZE-1:0] l,
                                                    input logic [1:0] k);
      return l[k*WORD_SIZE +: WORD_SIZE];
   endfunction

   // Bus outputs float whenever the engine is not in an owned READ phase.
   assign d_readM   = own ? 1'b1 : 1'bz;
   assign d_address = own ? addr : {WORD_SIZE{1'bz}};

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         addr           <= '0;
         rem            <= '0;
         line           <= '0;
         lat_cnt        <= '0;
         own            <= 1'b0;
         BR             <= 1'b0;
         ctl.busy       <= 1'b0;
         ctl.interrupt  <= 1'b0;
         ctl.dev_valid  <= 1'b0;
         ctl.dev_data   <= '0;
         ctl.dev_offset <= '0;
      end else begin
         ctl.interrupt <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ctl.cmd) begin
                  // Low address bits are dropped so every fetch is line aligned.
                  addr     <= ctl.cmd_addr & ~WORD_SIZE'(3);
                  rem      <= ctl.cmd_len;
                  ctl.busy <= 1'b1;
                  if (ctl.cmd_len == '0) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_REQ;
                     BR    <= 1'b1;
                  end
               end
            end

            S_REQ: begin
               if (BG) begin
                  state   <= S_READ;
                  own     <= 1'b1;
                  lat_cnt <= '0;
               end
            end

            S_READ: begin
               if (!BG) begin
                  // Grant withdrawn: let go of the bus, keep requesting, retry this line.
                  own   <= 1'b0;
                  state <= S_REQ;
               end else if (lat_cnt == LAT_LAST) begin
                  line           <= d_data;
                  own            <= 1'b0;
`ifndef DMA_BURST_HOLD_EN
                  BR             <= 1'b0;
`endif
                  state          <= S_STREAM;
                  ctl.dev_valid  <= 1'b1;
                  ctl.dev_data   <= word_of(d_data, 2'd0);
                  ctl.dev_offset <= 2'd0;
               end else begin
                  lat_cnt <= lat_cnt + CNT_W'(1);
               end
            end

            S_STREAM: begin
               if (ctl.dev_ready) begin
                  rem <= rem - WORD_SIZE'(1);
                  if (rem == WORD_SIZE'(1) || ctl.dev_offset == 2'd3) begin
                     ctl.dev_valid <= 1'b0;
                     if (rem == WORD_SIZE'(1)) begin
                        state <= S_DONE;
                        BR    <= 1'b0;
                     end else begin
                        addr <= addr + WORD_SIZE'(4);
`ifdef DMA_BURST_HOLD_EN
                        // Grant still held: skip arbitration and fetch the next line now.
                        if (BG) begin
                           state   <= S_READ;
                           own     <= 1'b1;
                           lat_cnt <= '0;
                        end else begin
                           state <= S_REQ;
                        end
`else
                        state <= S_REQ;
                        BR    <= 1'b1;
`endif
                     end
                  end else begin
                     ctl.dev_offset <= ctl.dev_offset + 2'd1;
                     ctl.dev_data   <= word_of(line, ctl.dev_offset + 2'd1);
                  end
               end
            end

            S_DONE: begin
               ctl.interrupt <= 1'b1;
               ctl.busy      <= 1'b0;
               state         <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
